// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter. It takes one byte per valid/ready handshake and
// shifts it out LSB-first as start + data + [parity] + stop bits. The framer generates
// its own bit period, so it needs no external baud tick.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between the
// data bits and the stop bit(s).
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic [DATA_BITS-1:0] data_q, data_d;
`endif

    logic cnt_wrap;
    logic accept;

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign accept   = tx_valid && (state_q == ST_IDLE);

    // Next-state, counters and line level.
    // The tx value is derived from the current state and is then registered, so the
    // line lags the state by one cycle: the start bit begins on the edge after the accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        data_d  = data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (accept) begin
                    shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    data_d  = tx_data;
`endif
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (cnt_wrap) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shreg_q[0];
                if (cnt_wrap) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                // Parity comes from the copy latched at accept; the shift register is empty by now.
                tx_d = ^data_q;
                if (cnt_wrap) begin
                    bit_d   = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (cnt_wrap) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state. A reset aborts any frame and drives the line back high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Data-path registers. They need no reset because they are only read after an accept.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
        data_q  <= data_d;
`endif
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer. It drives directed frames and checks every line cycle
// against a bit queue that is filled when each byte is offered. A second instance runs
// with two stop bits and a short bit period.
module tb_uart_tx_framer;

    localparam int C1 = 4;
    localparam int C2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx, tx_ready, tx_busy, tx_done;
    logic       tx2, tx_ready2, tx_busy2, tx_done2;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_framer #(.CLKS_PER_BIT(C1), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx_framer #(.CLKS_PER_BIT(C2), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line bits of one frame: start, data LSB-first, [even parity], stop bits.
    task automatic push_frame(input logic [7:0] d, input int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    // Offer a byte, wait (bounded) for ready, then step over the accept edge.
    task automatic send(input int sel, input logic [7:0] d);
        int n;
        n = 0;
        if (sel == 0) begin tx_data = d;  tx_valid = 1'b1;  end
        else          begin tx_data2 = d; tx_valid2 = 1'b1; end
        while (((sel == 0) ? tx_ready : tx_ready2) == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("ready_before_accept", (sel == 0) ? tx_ready : tx_ready2, 1'b1);
        tick();
        if (sel == 0) check("post_accept_tx_busy_ready", {tx, tx_busy, tx_ready}, 3'b110);
        else          check("post_accept_tx_busy_ready", {tx2, tx_busy2, tx_ready2}, 3'b110);
    endtask

    // Compare each line cycle against the queued bits and tx_done against the frame end.
    task automatic monitor(input int sel, input int c, input int abort_at,
                           input int mid_at, input logic [7:0] mid_val);
        int   nbits;
        int   last;
        logic b;
        logic otx, odone, ordy;
        nbits = exp_q.size();
        last  = nbits * c - 1;
        b     = 1'b1;
        for (int idx = 0; idx <= last; idx++) begin
            tick();
            if (idx == mid_at) tx_data = mid_val;
            otx   = (sel == 0) ? tx : tx2;
            odone = (sel == 0) ? tx_done : tx_done2;
            ordy  = (sel == 0) ? tx_ready : tx_ready2;
            if (idx % c == 0) b = exp_q.pop_front();
            check($sformatf("tx_bit%0d_cyc%0d", idx / c, idx), otx, b);
            check($sformatf("done_cyc%0d", idx), odone, (idx == last));
            if (idx == last) check("ready_at_done", ordy, 1'b1);
            if (idx == abort_at) return;
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_valid = 1'b0;  tx_data = 8'h00;
        tx_valid2 = 1'b0; tx_data2 = 8'h00;

        // Reset, then a long idle stretch.
        tick();
        tick();
        check("reset_state", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle_cyc%0d", i), {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
        end

        // Single frame 0xA5.
        push_frame(8'hA5, 1);
        send(0, 8'hA5);
        tx_valid = 1'b0;
        monitor(0, C1, -1, -1, 8'h00);
        tick();
        check("a5_done_single_pulse", {tx_done, tx_ready, tx}, 3'b011);

        // 0x3C, then 0xC3 held on the interface during the frame; tx_data is
        // disturbed mid-frame and must not affect the frame in flight.
        push_frame(8'h3C, 1);
        send(0, 8'h3C);
        tx_data = 8'h55;
        monitor(0, C1, -1, 13, 8'hC3);
        check("b2b_valid_held_in_done_cycle", {tx_valid, tx_done}, 2'b11);
        push_frame(8'hC3, 1);
        tick();
        check("b2b_accept_in_done_cycle", {tx, tx_busy, tx_ready, tx_done}, 4'b1100);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        monitor(0, C1, -1, -1, 8'h00);
        tick();
        check("c3_done_single_pulse", {tx_done, tx_ready}, 2'b01);

        // Reset during data bit 3 of 0xFF, then a clean 0x01 frame.
        push_frame(8'hFF, 1);
        send(0, 8'hFF);
        tx_valid = 1'b0;
        monitor(0, C1, 4 * C1 + 1, -1, 8'h00);
        rst = 1'b1;
        tick();
        check("abort_reset", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("after_abort_idle", {tx, tx_ready, tx_busy}, 3'b110);
        push_frame(8'h01, 1);
        send(0, 8'h01);
        tx_valid = 1'b0;
        monitor(0, C1, -1, -1, 8'h00);
        tick();

`ifdef UART_TX_PARITY_EN
        // Parity frames: odd popcount and even popcount.
        push_frame(8'h07, 1);
        send(0, 8'h07);
        tx_valid = 1'b0;
        monitor(0, C1, -1, -1, 8'h00);
        tick();
        push_frame(8'h03, 1);
        send(0, 8'h03);
        tx_valid = 1'b0;
        monitor(0, C1, -1, -1, 8'h00);
        tick();
`endif

        // Two stop bits with a two-cycle bit period.
        push_frame(8'h00, 2);
        send(1, 8'h00);
        tx_valid2 = 1'b0;
        monitor(1, C2, -1, -1, 8'h00);
        tick();
        check("dut2_done_single_pulse", {tx_done2, tx_ready2, tx2}, 3'b011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
